// File: rtl/cjoin5_sync.sv
// cjoin5_sync -- clocked 5-way join stage.
//
// Collects one 2-phase token from each of five branches. Each token is a
// toggle on its i_drive_5 bit with bundled data on i_dataN. Once all five
// have arrived, it presents the concatenated data on o_data. One cycle
// later it toggles o_driveNext. When the downstream stage toggles
// i_freeNext, every bit of o_free_5 toggles to hand the branches back.
//
// Ports:
//   clk          single clock
//   rstn         asynchronous active-low reset
//   i_drive_5    per-branch 2-phase request (bit n = branch n)
//   i_data0..4   per-branch bundled data, stable until o_free_5 toggles
//   o_free_5     per-branch 2-phase acknowledge
//   o_driveNext  2-phase request to the downstream stage
//   o_data       merged data, branch 0 in the MSBs, branch 4 in the LSBs
//   i_freeNext   2-phase acknowledge from the downstream stage
//   o_proto_err  sticky protocol-violation flag
//   o_timeout    sticky watchdog flag (only with CJOIN5_TIMEOUT_EN)
//
// Optional feature macro: CJOIN5_TIMEOUT_EN adds a 16-bit saturating
// watchdog counter and the o_timeout output.

module cjoin5_sync #(
  parameter int DATA_WIDTH0    = 5,
  parameter int DATA_WIDTH1    = 10,
  parameter int DATA_WIDTH2    = 3,
  parameter int DATA_WIDTH3    = 2,
  parameter int DATA_WIDTH4    = 5,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [4:0]             i_drive_5,
  input  logic [DATA_WIDTH0-1:0] i_data0,
  input  logic [DATA_WIDTH1-1:0] i_data1,
  input  logic [DATA_WIDTH2-1:0] i_data2,
  input  logic [DATA_WIDTH3-1:0] i_data3,
  input  logic [DATA_WIDTH4-1:0] i_data4,
  output logic [4:0]             o_free_5,
  output logic                   o_driveNext,
  output logic [DATA_WIDTH0+DATA_WIDTH1+DATA_WIDTH2+DATA_WIDTH3+DATA_WIDTH4-1:0] o_data,
  input  logic                   i_freeNext,
  output logic                   o_proto_err
`ifdef CJOIN5_TIMEOUT_EN
  ,
  output logic                   o_timeout
`endif
);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_LOAD,
    ST_SEND,
    ST_RELEASE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [SYNC_STAGES-1:0][4:0] r_driveSync;
  logic [4:0]                  r_driveHist;
  logic [SYNC_STAGES-1:0]      r_freeSync;
  logic                        r_freeHist;

  logic [4:0] w_driveEvt;
  logic       w_freeEvt;

  logic [4:0] r_flags;
  logic [DATA_WIDTH0-1:0] r_hold0;
  logic [DATA_WIDTH1-1:0] r_hold1;
  logic [DATA_WIDTH2-1:0] r_hold2;
  logic [DATA_WIDTH3-1:0] r_hold3;
  logic [DATA_WIDTH4-1:0] r_hold4;

  logic [4:0] w_capture;
  logic       w_protoViol;
  logic       w_loadData;
  logic       w_toggleDrive;
  logic       w_toggleFree;
  logic       w_clearFlags;

  // Synchronizer chains plus one history flop per line. A toggle shows up
  // as a one-cycle difference between the last sync stage and the history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_driveSync <= '0;
      r_driveHist <= '0;
      r_freeSync  <= '0;
      r_freeHist  <= 1'b0;
    end else begin
      r_driveSync[0] <= i_drive_5;
      r_freeSync[0]  <= i_freeNext;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_driveSync[s] <= r_driveSync[s-1];
        r_freeSync[s]  <= r_freeSync[s-1];
      end
      r_driveHist <= r_driveSync[SYNC_STAGES-1];
      r_freeHist  <= r_freeSync[SYNC_STAGES-1];
    end
  end

  assign w_driveEvt = r_driveSync[SYNC_STAGES-1] ^ r_driveHist;
  assign w_freeEvt  = r_freeSync[SYNC_STAGES-1] ^ r_freeHist;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and datapath strobes. A branch event is only legal in
  // COLLECT for a branch that has not arrived yet. A downstream free is
  // only legal in SEND. Illegal events raise the violation strobe and
  // are otherwise ignored.
  always_comb begin
    w_stateNext   = r_state;
    w_capture     = 5'b00000;
    w_protoViol   = 1'b0;
    w_loadData    = 1'b0;
    w_toggleDrive = 1'b0;
    w_toggleFree  = 1'b0;
    w_clearFlags  = 1'b0;

    case (r_state)
      ST_COLLECT: begin
        w_capture = w_driveEvt & ~r_flags;
        if (|(w_driveEvt & r_flags)) begin
          w_protoViol = 1'b1;
        end
        if (r_flags == 5'b11111) begin
          w_loadData  = 1'b1;
          w_stateNext = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (|w_driveEvt) begin
          w_protoViol = 1'b1;
        end
        w_toggleDrive = 1'b1;
        w_stateNext   = ST_SEND;
      end
      ST_SEND: begin
        if (|w_driveEvt) begin
          w_protoViol = 1'b1;
        end
        if (w_freeEvt) begin
          w_toggleFree = 1'b1;
          w_stateNext  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (|w_driveEvt) begin
          w_protoViol = 1'b1;
        end
        w_clearFlags = 1'b1;
        w_stateNext  = ST_COLLECT;
      end
      default: begin
        w_stateNext = ST_COLLECT;
      end
    endcase

    if (w_freeEvt && (r_state != ST_SEND)) begin
      w_protoViol = 1'b1;
    end
  end

  // Arrival flags and per-branch holding registers. Data is sampled when
  // the synchronized event appears; the bundled-data contract keeps it
  // stable from before the toggle until the free return.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_flags <= '0;
      r_hold0 <= '0;
      r_hold1 <= '0;
      r_hold2 <= '0;
      r_hold3 <= '0;
      r_hold4 <= '0;
    end else begin
      if (w_clearFlags) begin
        r_flags <= '0;
      end else begin
        r_flags <= r_flags | w_capture;
      end
      if (w_capture[0]) r_hold0 <= i_data0;
      if (w_capture[1]) r_hold1 <= i_data1;
      if (w_capture[2]) r_hold2 <= i_data2;
      if (w_capture[3]) r_hold3 <= i_data3;
      if (w_capture[4]) r_hold4 <= i_data4;
    end
  end

  // Outputs. o_data updates on the way into LOAD and o_driveNext toggles
  // on the way into SEND, so the data leads the request by one cycle.
  // o_free_5 toggles on the way into RELEASE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_data      <= '0;
      o_driveNext <= 1'b0;
      o_free_5    <= 5'b00000;
      o_proto_err <= 1'b0;
    end else begin
      if (w_loadData) begin
        o_data <= {r_hold0, r_hold1, r_hold2, r_hold3, r_hold4};
      end
      if (w_toggleDrive) begin
        o_driveNext <= ~o_driveNext;
      end
      if (w_toggleFree) begin
        o_free_5 <= ~o_free_5;
      end
      if (w_protoViol) begin
        o_proto_err <= 1'b1;
      end
    end
  end

`ifdef CJOIN5_TIMEOUT_EN
  logic [15:0] r_toCount;
  logic        w_toCountEn;

  // The watchdog counts while a round is stuck part-way: either some but
  // not all branches have arrived, or the downstream stage has not freed.
  assign w_toCountEn = ((r_state == ST_COLLECT) && (r_flags != 5'b00000) &&
                        (r_flags != 5'b11111)) || (r_state == ST_SEND);

  // Counter clears on any state change and saturates at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_toCount <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (r_state != w_stateNext) begin
        r_toCount <= '0;
      end else if (w_toCountEn && (r_toCount != 16'hFFFF)) begin
        r_toCount <= r_toCount + 16'd1;
      end
      if (r_toCount >= 16'(TIMEOUT_CYCLES)) begin
        o_timeout <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cjoin5_sync.sv
// tb_cjoin5_sync -- self-checking bench for cjoin5_sync.
//
// Rounds of branch toggles are driven from the main process. Each complete
// round pushes its expected merged word into a queue. A separate monitor
// pops that word whenever o_driveNext toggles and compares o_data. The main
// process also checks reset values, the free handshake, protocol-error
// behaviour and, when CJOIN5_TIMEOUT_EN is defined, the watchdog.

module tb_cjoin5_sync;

  localparam int W0 = 5;
  localparam int W1 = 10;
  localparam int W2 = 3;
  localparam int W3 = 2;
  localparam int W4 = 5;
  localparam int OW = W0 + W1 + W2 + W3 + W4;
`ifdef CJOIN5_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [4:0]    drive5;
  logic [W0-1:0] data0;
  logic [W1-1:0] data1;
  logic [W2-1:0] data2;
  logic [W3-1:0] data3;
  logic [W4-1:0] data4;
  logic [4:0]    free5;
  logic          driveNext;
  logic [OW-1:0] dataOut;
  logic          freeNext;
  logic          protoErr;
`ifdef CJOIN5_TIMEOUT_EN
  logic          timeoutOut;
`endif

  int nVec = 0;
  int nFail = 0;
  int nToggles = 0;
  int roundsDone = 0;
  logic [OW-1:0] expQ[$];
  logic [4:0] expFree = 5'b00000;
  logic expDrive = 1'b0;

  cjoin5_sync #(
    .DATA_WIDTH0(W0),
    .DATA_WIDTH1(W1),
    .DATA_WIDTH2(W2),
    .DATA_WIDTH3(W3),
    .DATA_WIDTH4(W4),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_drive_5(drive5),
    .i_data0(data0),
    .i_data1(data1),
    .i_data2(data2),
    .i_data3(data3),
    .i_data4(data4),
    .o_free_5(free5),
    .o_driveNext(driveNext),
    .o_data(dataOut),
    .i_freeNext(freeNext),
    .o_proto_err(protoErr)
`ifdef CJOIN5_TIMEOUT_EN
    ,
    .o_timeout(timeoutOut)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every o_driveNext toggle consumes one expected word. The data
  // must already be on o_data one cycle before the request.
  initial begin
    logic          prevDrv;
    logic [OW-1:0] prevData;
    logic [OW-1:0] e;
    prevDrv  = 1'b0;
    prevData = '0;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && driveNext !== prevDrv) begin
        nToggles++;
        if (expQ.size() == 0) begin
          nVec++;
          nFail++;
          $display("[TB] FAIL unexpected driveNext toggle: got data 0x%0h, expected no request", dataOut);
        end else begin
          e = expQ.pop_front();
          checkOutput("merged data", 32'(dataOut), 32'(e));
          checkOutput("data before request", 32'(prevData), 32'(e));
        end
      end
      prevDrv  = driveNext;
      prevData = dataOut;
    end
  end

  // Toggle the masked branches at a falling edge with new data on them.
  task automatic applyStimulus(input logic [4:0] mask, input logic [W0-1:0] d0,
                               input logic [W1-1:0] d1, input logic [W2-1:0] d2,
                               input logic [W3-1:0] d3, input logic [W4-1:0] d4);
    @(negedge clk);
    if (mask[0]) data0 = d0;
    if (mask[1]) data1 = d1;
    if (mask[2]) data2 = d2;
    if (mask[3]) data3 = d3;
    if (mask[4]) data4 = d4;
    drive5 = drive5 ^ mask;
  endtask

  // Reset with random input levels, check that all outputs are cleared,
  // then restart every toggle level at 0 and release.
  task automatic resetDut();
    @(negedge clk);
    rstn     = 1'b0;
    drive5   = 5'($urandom);
    freeNext = 1'($urandom);
    data0 = W0'($urandom);
    data1 = W1'($urandom);
    data2 = W2'($urandom);
    data3 = W3'($urandom);
    data4 = W4'($urandom);
    repeat (3) @(negedge clk);
    checkOutput("reset free5", 32'(free5), 32'h0);
    checkOutput("reset driveNext", 32'(driveNext), 32'h0);
    checkOutput("reset data", 32'(dataOut), 32'h0);
    checkOutput("reset protoErr", 32'(protoErr), 32'h0);
    drive5   = 5'b00000;
    freeNext = 1'b0;
    expFree  = 5'b00000;
    expDrive = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Wait for the request, confirm the branches are held, then free the
  // round and confirm o_free_5 toggles within four cycles.
  task automatic finishRound(input logic [OW-1:0] expData);
    expQ.push_back(expData);
    expDrive = ~expDrive;
    for (int k = 0; k < 20 && driveNext !== expDrive; k++) @(negedge clk);
    checkOutput("driveNext toggle", 32'(driveNext), 32'(expDrive));
    repeat (3) @(negedge clk);
    checkOutput("free held until freeNext", 32'(free5), 32'(expFree));
    checkOutput("data stable in SEND", 32'(dataOut), 32'(expData));
    @(negedge clk);
    freeNext = ~freeNext;
    expFree  = ~expFree;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (free5 === expFree) break;
    end
    checkOutput("free return", 32'(free5), 32'(expFree));
    repeat (2) @(negedge clk);
    roundsDone++;
  endtask

  // mode 0: branches 0..4 one per cycle, 1: all at once, 2: 4..0.
  task automatic runRound(input int mode, input logic [W0-1:0] d0,
                          input logic [W1-1:0] d1, input logic [W2-1:0] d2,
                          input logic [W3-1:0] d3, input logic [W4-1:0] d4);
    case (mode)
      0: for (int i = 0; i < 5; i++) applyStimulus(5'b00001 << i, d0, d1, d2, d3, d4);
      1: applyStimulus(5'b11111, d0, d1, d2, d3, d4);
      default: for (int i = 4; i >= 0; i--) applyStimulus(5'b00001 << i, d0, d1, d2, d3, d4);
    endcase
    finishRound({d0, d1, d2, d3, d4});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rstn     = 1'b0;
    drive5   = 5'b00000;
    freeNext = 1'b0;
    data0 = '0;
    data1 = '0;
    data2 = '0;
    data3 = '0;
    data4 = '0;

    resetDut();
    repeat (8) @(negedge clk);
    checkOutput("idle free5", 32'(free5), 32'h0);
    checkOutput("idle driveNext", 32'(driveNext), 32'h0);
    checkOutput("idle protoErr", 32'(protoErr), 32'h0);

    $display("[TB] in-order round");
    runRound(0, 5'h15, 10'h2AA, 3'h5, 2'h2, 5'h1F);
    checkOutput("free after round A", 32'(free5), 32'h1F);

    $display("[TB] simultaneous round");
    runRound(1, 5'h07, 10'h123, 3'h6, 2'h1, 5'h0C);
    checkOutput("free after round B", 32'(free5), 32'h00);

    $display("[TB] reverse-order round");
    runRound(2, 5'h1F, 10'h3FF, 3'h0, 2'h2, 5'h01);
    checkOutput("protoErr after clean rounds", 32'(protoErr), 32'h0);

    $display("[TB] double toggle on branch 2");
    applyStimulus(5'b00001, 5'h0A, 10'h155, 3'h3, 2'h1, 5'h0E);
    applyStimulus(5'b00010, 5'h0A, 10'h155, 3'h3, 2'h1, 5'h0E);
    applyStimulus(5'b00100, 5'h0A, 10'h155, 3'h3, 2'h1, 5'h0E);
    repeat (6) @(negedge clk);
    checkOutput("protoErr before double toggle", 32'(protoErr), 32'h0);
    applyStimulus(5'b00100, 5'h0A, 10'h155, 3'h6, 2'h1, 5'h0E);
    repeat (6) @(negedge clk);
    checkOutput("protoErr after double toggle", 32'(protoErr), 32'h1);
    checkOutput("no request on partial round", 32'(driveNext), 32'(expDrive));
    applyStimulus(5'b01000, 5'h0A, 10'h155, 3'h6, 2'h1, 5'h0E);
    applyStimulus(5'b10000, 5'h0A, 10'h155, 3'h6, 2'h1, 5'h0E);
    finishRound({5'h0A, 10'h155, 3'h3, 2'h1, 5'h0E});
    checkOutput("protoErr sticky", 32'(protoErr), 32'h1);

    $display("[TB] reset mid-round");
    applyStimulus(5'b00001, 5'h11, 10'h0F0, 3'h7, 2'h0, 5'h00);
    applyStimulus(5'b00010, 5'h11, 10'h0F0, 3'h7, 2'h0, 5'h00);
    applyStimulus(5'b00100, 5'h11, 10'h0F0, 3'h7, 2'h0, 5'h00);
    repeat (6) @(negedge clk);
    resetDut();
    repeat (4) @(negedge clk);
    runRound(0, 5'h03, 10'h3C3, 3'h1, 2'h3, 5'h10);
    checkOutput("protoErr after fresh round", 32'(protoErr), 32'h0);

    $display("[TB] freeNext during COLLECT");
    @(negedge clk);
    freeNext = ~freeNext;
    repeat (6) @(negedge clk);
    checkOutput("protoErr after stray freeNext", 32'(protoErr), 32'h1);
    checkOutput("driveNext after stray freeNext", 32'(driveNext), 32'(expDrive));
    checkOutput("free5 after stray freeNext", 32'(free5), 32'(expFree));
    runRound(1, 5'h1E, 10'h001, 3'h2, 2'h0, 5'h15);

`ifdef CJOIN5_TIMEOUT_EN
    $display("[TB] watchdog");
    resetDut();
    repeat (4) @(negedge clk);
    runRound(1, 5'h05, 10'h0AA, 3'h4, 2'h3, 5'h1A);
    checkOutput("timeout after normal round", 32'(timeoutOut), 32'h0);
    applyStimulus(5'b00001, 5'h09, 10'h000, 3'h0, 2'h0, 5'h00);
    repeat (30) @(negedge clk);
    checkOutput("timeout after stuck round", 32'(timeoutOut), 32'h1);
    checkOutput("no request while stuck", 32'(driveNext), 32'(expDrive));
`endif

    repeat (5) @(negedge clk);
    checkOutput("one request per round", 32'(nToggles), 32'(roundsDone));
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/cjoin5_sync.md
Name: cjoin5_sync

Overview:
- Clocked 5-way join stage that sits directly downstream of the 5-way splitter.
- Collects the five branch tokens (2-phase drive toggles plus bundled data) after per-branch processing.
- Once all five have arrived, emits one merged token with concatenated data to the next stage.
- Returns a free toggle on every branch only after the downstream stage has acknowledged.

Parameters:
- DATA_WIDTH0, 5, branch 0 data width
- DATA_WIDTH1, 10, branch 1 data width
- DATA_WIDTH2, 3, branch 2 data width
- DATA_WIDTH3, 2, branch 3 data width
- DATA_WIDTH4, 5, branch 4 data width
- SYNC_STAGES, 2, flip-flop synchronizer depth on every incoming handshake line (legal range 2..4)
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  single clock domain of this block
- rstn  in  1  asynchronous active-low reset
- i_drive_5  in  5  per-branch 2-phase request (one toggle = one token)
- i_data0  in  DATA_WIDTH0  branch 0 bundled data; stable from before its toggle until the free return
- i_data1  in  DATA_WIDTH1  branch 1 bundled data
- i_data2  in  DATA_WIDTH2  branch 2 bundled data
- i_data3  in  DATA_WIDTH3  branch 3 bundled data
- i_data4  in  DATA_WIDTH4  branch 4 bundled data
- o_free_5  out  5  per-branch 2-phase acknowledge
- o_driveNext  out  1  2-phase request to the downstream stage
- o_data  out  sum of DATA_WIDTH0..4  merged data, branch 0 in the MSBs, branch 4 in the LSBs
- i_freeNext  in  1  2-phase acknowledge from the downstream stage
- o_proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (asynchronous, rstn=0): all synchronizers, edge-history registers, arrival flags, o_free_5, o_driveNext, o_data and o_proto_err are cleared to 0. State is COLLECT.
- Reset mid-round discards any partial round. Neighbouring stages share rstn, so every toggle level restarts at 0.
- Input conditioning:
  - Each i_drive_5 bit and i_freeNext passes through a SYNC_STAGES flip-flop synchronizer.
  - One further history flop per line detects a toggle as a 1-cycle event.
- Branch data capture: on a branch toggle event in COLLECT, that branch's i_dataN is latched into its holding register and its arrival flag is set. Latency from input toggle to flag set is SYNC_STAGES+1 cycles.
- States:
  - COLLECT: accept branch events in any order, including several in the same cycle. When all five flags are set, go to LOAD.
  - LOAD (1 cycle): o_data <= concatenation of the holding registers. Go to SEND.
  - SEND: o_driveNext toggles on entry, exactly one cycle after o_data updates, so bundled data precedes the request. Stay until the synchronized i_freeNext toggle event, then go to RELEASE.
  - RELEASE (1 cycle): all 5 bits of o_free_5 toggle simultaneously, all arrival flags clear, return to COLLECT.
- Minimum round, measured from the last branch arrival flag to the o_free_5 toggle: LOAD + SEND entry + SYNC_STAGES+1 for the freeNext round trip + RELEASE.
- o_data holds its value outside LOAD; it is never changed while SEND is active.
- Protocol violations (o_proto_err set and sticky until reset):
  - A branch toggle event arrives for a branch whose flag is already set.
  - A branch event occurs in LOAD, SEND or RELEASE.
  - An i_freeNext toggle event occurs outside SEND.
  - In every case the offending event is otherwise ignored: no data capture and no state change.
- Simultaneous events: a branch event and the RELEASE clear in the same cycle cannot occur legally, because branches cannot toggle before o_free_5 does. If it happens, it is flagged as a violation.
- Toggle level wrap: 2-phase levels simply alternate; there is no counter overflow.

Optional Feature:
- Macro: CJOIN5_TIMEOUT_EN.
- With the macro defined:
  - Adds output o_timeout (1 bit, reset 0) and a 16-bit saturating counter.
  - The counter counts cycles spent in COLLECT with at least one but not all flags set, or in SEND.
  - It clears on every state change.
  - When the counter reaches TIMEOUT_CYCLES, o_timeout is set, sticky until reset. The state machine is not otherwise affected.
- Without the macro: no counter and no o_timeout port; behaviour is otherwise identical.

Test Plan:
- Reset: hold rstn=0 with random input levels -> all outputs 0. Release -> no output activity until branch toggles arrive.
- In-order join: toggle branches 0..4 one per cycle with data 0x15, 0x2AA, 0x5, 0x2, 0x1F (SYNC_STAGES=2) -> o_data = {0x15,0x2AA,0x5,0x2,0x1F}. o_driveNext toggles 1 cycle after o_data changes. o_free_5 stays 0 until i_freeNext toggles, then becomes 5'b11111 within 4 cycles.
- Simultaneous and reverse order: all 5 toggle in the same cycle, then in order 4..0 for the second round -> one o_driveNext toggle per round, with correct data for each. o_free_5 returns to 5'b00000 after round 2.
- Violations: toggle branch 2 twice before free returns -> o_proto_err=1, and the captured branch 2 data is the first value. Toggle i_freeNext during COLLECT -> o_proto_err=1, state unchanged.
- Reset mid-round: 3 branches arrived, assert rstn -> flags cleared. A subsequent full round completes normally with fresh data.
- Timeout (CJOIN5_TIMEOUT_EN, TIMEOUT_CYCLES=16): toggle only branch 0 -> o_timeout=1 after 16 cycles in partial COLLECT. A normal full round keeps o_timeout=0.
